// File: rtl/ktlink_oe_sequencer.sv
// Break-before-make sequencer for the KT-Link buffer enables and JTAG/SWD mode select.
// Define KTLINK_LED_STRETCH_EN to stretch activity pulses on LED for LED_HOLD_CYCLES.
module ktlink_oe_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int FILTER_CYCLES   = 4,
    parameter int GUARD_CYCLES    = 8,
    parameter int LED_HOLD_CYCLES = 1200000
) (
    input  logic CLK,
    input  logic RST,
    input  logic FT_TCK_OE,
    input  logic FT_TDI_OE,
    input  logic FT_nTRST_OE,
    input  logic FT_nSRST_OE,
    input  logic FT_TMS_OE,
    input  logic FT_SWD_EN,
    input  logic FT_LED_OUT,
    output logic TCK_OE_N,
    output logic TDI_OE_N,
    output logic nTRST_OE_N,
    output logic nSRST_OE_N,
    output logic TMS_OE_N,
    output logic SWD_EN_Q,
    output logic BUSY,
    output logic LED
);
    localparam int CNT_FG  = (FILTER_CYCLES > GUARD_CYCLES) ? FILTER_CYCLES : GUARD_CYCLES;
    localparam int CNT_MAX = (CNT_FG > 2) ? CNT_FG : 2;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {ST_RUN, ST_FILTER, ST_BREAK, ST_SWITCH} state_t;

    generate
        if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || GUARD_CYCLES < 1 || LED_HOLD_CYCLES < 1) begin : g_param_check
            $error("ktlink_oe_sequencer: parameter out of range");
        end
    endgenerate

    // Vector layout: [6]=LED, [5]=mode, [4]=TMS, [3]=nSRST, [2]=nTRST, [1]=TDI, [0]=TCK
    logic [6:0] w_raw;
    logic [6:0] r_sync [SYNC_STAGES];
    logic [5:0] w_s;
    logic       w_led_s;

    assign w_raw   = {FT_LED_OUT, FT_SWD_EN, FT_TMS_OE, FT_nSRST_OE, FT_nTRST_OE, FT_TDI_OE, FT_TCK_OE};
    assign w_s     = r_sync[SYNC_STAGES-1][5:0];
    assign w_led_s = r_sync[SYNC_STAGES-1][6];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [5:0]       r_c, w_c_nxt;
    logic [5:0]       r_n, w_n_nxt;
    logic [4:0]       r_oe_n, w_oe_n_nxt;
    logic             r_swd_en, w_swd_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_led;

    // Outputs are registered from next-state values so they change on the same edge as the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_c      <= '1;
            r_n      <= '1;
            r_oe_n   <= '1;
            r_swd_en <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_c      <= w_c_nxt;
            r_n      <= w_n_nxt;
            r_oe_n   <= w_oe_n_nxt;
            r_swd_en <= w_swd_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_c_nxt     = r_c;
        w_n_nxt     = r_n;
        case (r_state)
            ST_RUN: begin
                if (w_s != r_c) begin
                    w_n_nxt     = w_s;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (w_s == r_c) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end else if (w_s != r_n) begin
                    w_n_nxt   = w_s;
                    w_cnt_nxt = '0;
                end else if (r_cnt == FILT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_n[5] == r_c[5]) begin
                        w_c_nxt     = r_n;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_BREAK: begin
                if (r_cnt == GUARD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SWITCH;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                if (r_cnt == GUARD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_c_nxt     = r_n;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_oe_n_nxt = w_c_nxt[4:0];
        w_swd_nxt  = w_c_nxt[5];
        w_busy_nxt = (w_state_nxt != ST_RUN);
        case (w_state_nxt)
            ST_BREAK:  w_oe_n_nxt = '1;
            ST_SWITCH: begin
                w_oe_n_nxt = '1;
                w_swd_nxt  = w_n_nxt[5];
            end
            default: ;
        endcase
    end

`ifdef KTLINK_LED_STRETCH_EN
    localparam int HOLD_W = $clog2(LED_HOLD_CYCLES + 1);
    logic [HOLD_W-1:0] r_hold;

    // Every low sample reloads the hold so the LED stays lit through bursts of activity.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hold <= '0;
            r_led  <= 1'b0;
        end else if (!w_led_s) begin
            r_hold <= HOLD_W'(LED_HOLD_CYCLES - 1);
            r_led  <= 1'b1;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
        end else begin
            r_led <= 1'b0;
        end
    end
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_led <= 1'b0;
        else     r_led <= ~w_led_s;
    end
`endif

    assign {TMS_OE_N, nSRST_OE_N, nTRST_OE_N, TDI_OE_N, TCK_OE_N} = r_oe_n;
    assign SWD_EN_Q = r_swd_en;
    assign BUSY     = r_busy;
    assign LED      = r_led;
endmodule

// File: tb/tb_ktlink_oe_sequencer.sv
// Scoreboard bench for ktlink_oe_sequencer: expected output vectors are queued per cycle
// when stimulus is applied and compared as the DUT advances.
module tb_ktlink_oe_sequencer;
`ifdef KTLINK_LED_STRETCH_EN
    localparam int LED_ON = 10;
`else
    localparam int LED_ON = 1;
`endif
    localparam logic [7:0] IDLE = 8'b0011_1111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ft_tck_oe = 1'b1, ft_tdi_oe = 1'b1, ft_ntrst_oe = 1'b1, ft_nsrst_oe = 1'b1;
    logic ft_tms_oe = 1'b1, ft_swd_en = 1'b1, ft_led_out = 1'b1;
    logic tck_oe_n, tdi_oe_n, ntrst_oe_n, nsrst_oe_n, tms_oe_n, swd_en_q, busy, led;
    logic [7:0] obs;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int checks = 0;
    int errors = 0;

    // obs = {LED, BUSY, SWD_EN_Q, TMS, nSRST, nTRST, TDI, TCK}
    assign obs = {led, busy, swd_en_q, tms_oe_n, nsrst_oe_n, ntrst_oe_n, tdi_oe_n, tck_oe_n};

    always #5 clk = ~clk;

    ktlink_oe_sequencer #(
        .SYNC_STAGES(2), .FILTER_CYCLES(4), .GUARD_CYCLES(3), .LED_HOLD_CYCLES(10)
    ) dut (
        .CLK(clk), .RST(rst),
        .FT_TCK_OE(ft_tck_oe), .FT_TDI_OE(ft_tdi_oe), .FT_nTRST_OE(ft_ntrst_oe),
        .FT_nSRST_OE(ft_nsrst_oe), .FT_TMS_OE(ft_tms_oe), .FT_SWD_EN(ft_swd_en),
        .FT_LED_OUT(ft_led_out),
        .TCK_OE_N(tck_oe_n), .TDI_OE_N(tdi_oe_n), .nTRST_OE_N(ntrst_oe_n),
        .nSRST_OE_N(nsrst_oe_n), .TMS_OE_N(tms_oe_n), .SWD_EN_Q(swd_en_q),
        .BUSY(busy), .LED(led)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_q.push_back(IDLE);
        repeat (3) step();
        checks++;
        e = exp_q.pop_front();
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_hold got %b expected %b", obs, e);
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) exp_q.push_back(IDLE);
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_oe_only();
        for (int k = 1; k <= 12; k++) begin
            e = IDLE;
            if (k >= 3 && k <= 6) e[6] = 1'b1;
            if (k >= 7) e[0] = 1'b0;
            exp_q.push_back(e);
        end
        ft_tck_oe = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL oe_only cyc %0d got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= 10; k++) begin
            e = 8'b0011_1110;
            if (k == 3 || k == 4) e[6] = 1'b1;
            exp_q.push_back(e);
        end
        ft_tms_oe = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 2) ft_tms_oe = 1'b1;
            checks++;
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL glitch cyc %0d got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_mode_switch();
        for (int k = 1; k <= 10; k++) begin
            e = 8'b0011_1110;
            if (k >= 3 && k <= 6) e[6] = 1'b1;
            if (k >= 7) e[4] = 1'b0;
            exp_q.push_back(e);
        end
        ft_tms_oe = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL tms_commit cyc %0d got %b expected %b", k, obs, e);
            end
        end
        for (int k = 1; k <= 16; k++) begin
            if (k <= 2)       e = 8'b0010_1110;
            else if (k <= 6)  e = 8'b0110_1110;
            else if (k <= 9)  e = 8'b0111_1111;
            else if (k <= 12) e = 8'b0101_1111;
            else              e = 8'b0000_1110;
            exp_q.push_back(e);
        end
        ft_swd_en = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL mode_switch cyc %0d got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_break_ignore();
        for (int k = 1; k <= 22; k++) begin
            if (k <= 2)       e = 8'b0000_1110;
            else if (k <= 6)  e = 8'b0100_1110;
            else if (k <= 9)  e = 8'b0101_1111;
            else if (k <= 12) e = 8'b0111_1111;
            else if (k == 13) e = 8'b0010_1110;
            else if (k <= 17) e = 8'b0110_1110;
            else              e = 8'b0010_1100;
            exp_q.push_back(e);
        end
        ft_swd_en = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            step();
            if (k == 8) ft_tdi_oe = 1'b0;
            checks++;
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL break_ignore cyc %0d got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 11; k++) begin
            if (k <= 2)      e = 8'b0010_1100;
            else if (k <= 6) e = 8'b0110_1100;
            else if (k <= 9) e = 8'b0111_1111;
            else             e = 8'b0101_1111;
            exp_q.push_back(e);
        end
        ft_swd_en = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            checks++;
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL pre_reset cyc %0d got %b expected %b", k, obs, e);
            end
        end
        exp_q.push_back(IDLE);
        rst = 1'b1;
        ft_swd_en = 1'b1;
        ft_tck_oe = 1'b1;
        ft_tdi_oe = 1'b1;
        ft_tms_oe = 1'b1;
        #1;
        checks++;
        e = exp_q.pop_front();
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_in_switch got %b expected %b", obs, e);
        end
        repeat (2) step();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) exp_q.push_back(IDLE);
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL post_reset cyc %0d got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic test_led(input int len);
        for (int k = 1; k <= len + LED_ON + 5; k++) begin
            e = IDLE;
            if (k >= 3 && k <= len + 1 + LED_ON) e[7] = 1'b1;
            exp_q.push_back(e);
        end
        ft_led_out = 1'b0;
        for (int k = 1; k <= len + LED_ON + 5; k++) begin
            step();
            if (k == len) ft_led_out = 1'b1;
            checks++;
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL led_len%0d cyc %0d got %b expected %b", len, k, obs, e);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_oe_only();
        test_glitch();
        test_mode_switch();
        test_break_ignore();
        test_reset_mid();
        test_led(1);
        test_led(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ktlink_oe_sequencer.md
# ktlink_oe_sequencer

Synchronous break-before-make controller for the KT-Link buffer enables and JTAG/SWD mode select. It samples the FT2232 ACBUS output-enable strobes and the mode line, glitch-filters them, and commits a new buffer configuration only after all target-side drivers have been tristated for a guard interval. Its outputs feed the tristate and mux logic in place of the raw FTDI pins, so a mode flip never lets the CPLD and the target drive TMS/SWDIO at the same time. It also generates the activity LED drive.

## Interface
- SYNC_STAGES, 2: flip-flop stages per asynchronous input (min 2).
- FILTER_CYCLES, 4: consecutive identical samples required before a new configuration is accepted (min 1).
- GUARD_CYCLES, 8: length of each of the BREAK and SWITCH phases (min 1).
- LED_HOLD_CYCLES, 1200000: LED on-time after activity; used only with the stretch feature.
- CLK  in  1: system clock.
- RST  in  1: asynchronous, active-high reset.
- FT_TCK_OE, FT_TDI_OE, FT_nTRST_OE, FT_nSRST_OE, FT_TMS_OE  in  1 each: raw active-low enable requests from the FTDI.
- FT_SWD_EN  in  1: raw mode line; 1 = JTAG routing, 0 = SWD routing.
- FT_LED_OUT  in  1: raw active-low activity indication.
- TCK_OE_N, TDI_OE_N, nTRST_OE_N, nSRST_OE_N, TMS_OE_N  out  1 each: committed active-low enables to the buffer logic.
- SWD_EN_Q  out  1: committed mode select, same polarity as FT_SWD_EN.
- BUSY  out  1: high whenever the FSM is not in RUN.
- LED  out  1: active-high LED drive.

## Operation
- All 7 raw inputs pass through SYNC_STAGES synchronisers. Synchroniser reset values: OE bits 1, mode 1, LED 1.
- Sample vector S is {mode, 5 OE bits}. Committed vector C drives the outputs.
- FSM states:
  - RUN: outputs follow C. If S != C, latch candidate N = S, clear the counter, and go to FILTER.
  - FILTER: outputs follow C. If S == C, go to RUN (glitch rejected). If S != N, set N = S and restart the count. Once S == N for FILTER_CYCLES consecutive cycles:
    - If N.mode == C.mode, set C = N and go to RUN (OE-only change, no break).
    - Otherwise go to BREAK.
  - BREAK: all OE_N forced to 1; SWD_EN_Q keeps the old mode. Lasts GUARD_CYCLES cycles, then go to SWITCH.
  - SWITCH: all OE_N still forced to 1; SWD_EN_Q = N.mode from the first SWITCH cycle. Lasts GUARD_CYCLES cycles, then set C = N and go to RUN.
- Input changes during BREAK/SWITCH are ignored. N is frozen. Any remaining S != C difference is handled from RUN afterwards.
- Reset mid-sequence returns immediately to the RUN state with C = reset value; no partial state survives.
- Reset values: all OE_N = 1, SWD_EN_Q = 1, BUSY = 0, LED = 0, state RUN, counter 0.
- Counter width is clog2(max(FILTER_CYCLES, GUARD_CYCLES, 2)) bits.

## Timing
- A raw input edge reaches S after SYNC_STAGES clock edges.
- OE-only change: outputs update SYNC_STAGES + FILTER_CYCLES + 1 cycles after the raw edge. BUSY is high for FILTER_CYCLES cycles.
- Mode change:
  - All OE_N go to 1 at the first BREAK cycle.
  - SWD_EN_Q toggles GUARD_CYCLES cycles later.
  - New OE_N values appear GUARD_CYCLES cycles after that.
  - BUSY is high for FILTER_CYCLES + 2*GUARD_CYCLES cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- KTLINK_LED_STRETCH_EN defined:
  - LED goes to 1 in the cycle after the synchronised FT_LED_OUT is seen at 0.
  - LED stays 1 for LED_HOLD_CYCLES cycles after the last such cycle; every new low sample reloads the hold counter.
- KTLINK_LED_STRETCH_EN undefined:
  - LED = registered ~(synchronised FT_LED_OUT).
  - No hold counter is built, and LED_HOLD_CYCLES is ignored.

## Test plan
Bench parameters: SYNC_STAGES=2, FILTER_CYCLES=4, GUARD_CYCLES=3, LED_HOLD_CYCLES=10.
- Reset, then hold all inputs at reset values -> all OE_N=1, SWD_EN_Q=1, BUSY=0, LED=0 indefinitely.
- Drive FT_TCK_OE 1->0 at cycle 0 -> TCK_OE_N falls at cycle 7; BUSY high cycles 3-6; SWD_EN_Q unchanged.
- Pulse FT_TMS_OE low for 2 cycles -> BUSY pulses, TMS_OE_N stays 1.
- With TMS_OE_N=0 committed, drive FT_SWD_EN 1->0 -> TMS_OE_N=1 for 6 cycles; SWD_EN_Q falls after 3 of them; TMS_OE_N returns to 0 at the end.
- Toggle FT_TDI_OE during BREAK -> it is ignored until RUN, then processed as a fresh OE-only change.
- Assert RST during SWITCH -> reset values immediately. With KTLINK_LED_STRETCH_EN, a 1-cycle low on FT_LED_OUT -> LED high for exactly 10 cycles.
